// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared widths, preamble lengths and FSM encoding for the TX frame assembler
package tx_pkg;

    localparam int IQ_W    = 8;
    localparam int STS_LEN = 160;
    localparam int LTS_LEN = 160;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STS  = 3'd1,
        ST_LTS  = 3'd2,
        ST_DATA = 3'd3,
        ST_TAIL = 3'd4
    } tx_state_t;

endpackage

// File: rtl/iq_sat_add.sv
// rtl/iq_sat_add.sv - one rail of sat(tail + (data >>> 1)) at W+1 bits, clipped to W-bit signed range
module iq_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] tail,
    input  logic [W-1:0] data,
    output logic [W-1:0] sum
);

    logic [W-1:0] half;
    logic [W:0]   wide;

    assign half = {data[W-1], data[W-1:1]};
    assign wide = {tail[W-1], tail} + {half[W-1], half};

    // The two top bits disagree only when the signed sum left the W-bit range.
    always_comb begin
        sum = wide[W-1:0];
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/tx_frame_assembler.sv
// rtl/tx_frame_assembler.sv - sequences STS, LTS and data samples into one frame with LTS tail overlap-add
module tx_frame_assembler #(
    parameter int IQ_W    = tx_pkg::IQ_W,
    parameter int STS_LEN = tx_pkg::STS_LEN,
    parameter int LTS_LEN = tx_pkg::LTS_LEN,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_clr,
    input  logic             tx_start,
    output logic             sts_en,
    input  logic [IQ_W-1:0]  sts_re,
    input  logic [IQ_W-1:0]  sts_im,
    input  logic             sts_dv,
    output logic             lts_en,
    input  logic [IQ_W-1:0]  lts_re,
    input  logic [IQ_W-1:0]  lts_im,
    input  logic             lts_dv,
    input  logic             lts_done,
    output logic             data_en,
    input  logic [IQ_W-1:0]  data_re,
    input  logic [IQ_W-1:0]  data_im,
    input  logic             data_dv,
    input  logic             data_last,
    output logic [IQ_W-1:0]  tx_re,
    output logic [IQ_W-1:0]  tx_im,
    output logic             tx_dv,
    output logic [CNT_W-1:0] tx_index,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             err_underrun
);

    import tx_pkg::tx_state_t;
    import tx_pkg::ST_IDLE;
    import tx_pkg::ST_STS;
    import tx_pkg::ST_LTS;
    import tx_pkg::ST_DATA;
    import tx_pkg::ST_TAIL;

    localparam int MAX_LEN = (STS_LEN > LTS_LEN) ? STS_LEN : LTS_LEN;
    localparam int SEG_W   = $clog2(MAX_LEN) + 1;
    localparam logic [SEG_W-1:0] STS_LAST = SEG_W'(STS_LEN - 1);
    localparam logic [SEG_W-1:0] LTS_LAST = SEG_W'(LTS_LEN - 1);

    tx_state_t        state, state_nxt;
    logic [SEG_W-1:0] seg_cnt, seg_cnt_nxt;
    logic             first_seen;
    logic             data_en_q;
    logic [IQ_W-1:0]  tail_re, tail_im;
    logic [IQ_W-1:0]  add_re, add_im, sat_re, sat_im;
    logic [IQ_W-1:0]  out_re, out_im;
    logic             out_dv;
    logic             start_ok, sts_hit, sts_end, lts_hit, lts_end;
    logic             tail_hit, data_hit, data_end, gap;

    assign start_ok = (state == ST_IDLE) && tx_start;
    assign sts_hit  = (state == ST_STS) && sts_dv;
    assign sts_end  = sts_hit && (seg_cnt == STS_LAST);
    assign lts_hit  = (state == ST_LTS) && lts_dv && !lts_done;
    assign lts_end  = lts_hit && (seg_cnt == LTS_LAST);
    // The windowed tail may arrive in the same cycle as the first data sample.
    assign tail_hit = ((state == ST_LTS) || ((state == ST_DATA) && !first_seen)) && lts_dv && lts_done;
    assign data_hit = (state == ST_DATA) && data_dv;
    assign data_end = data_hit && data_last;
    assign gap      = (state == ST_DATA) && first_seen && !data_dv;

    assign lts_en  = sts_end && !tx_clr;
    assign data_en = (lts_end && !tx_clr) || data_en_q;

    // A zero addend turns the adder into the plain halving needed for the last sample.
    assign add_re = first_seen ? '0 : (tail_hit ? lts_re : tail_re);
    assign add_im = first_seen ? '0 : (tail_hit ? lts_im : tail_im);

    iq_sat_add #(.W(IQ_W)) u_sat_re (.tail(add_re), .data(data_re), .sum(sat_re));
    iq_sat_add #(.W(IQ_W)) u_sat_im (.tail(add_im), .data(data_im), .sum(sat_im));

    always_comb begin
        state_nxt   = state;
        seg_cnt_nxt = seg_cnt;
        out_dv      = 1'b0;
        out_re      = sts_re;
        out_im      = sts_im;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nxt   = ST_STS;
                    seg_cnt_nxt = '0;
                end
            end
            ST_STS: begin
                if (sts_hit) begin
                    out_dv      = 1'b1;
                    seg_cnt_nxt = sts_end ? '0 : seg_cnt + SEG_W'(1);
                    if (sts_end) state_nxt = ST_LTS;
                end
            end
            ST_LTS: begin
                if (lts_hit) begin
                    out_dv      = 1'b1;
                    out_re      = lts_re;
                    out_im      = lts_im;
                    seg_cnt_nxt = lts_end ? '0 : seg_cnt + SEG_W'(1);
                    if (lts_end) state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_hit) begin
                    out_dv = 1'b1;
                    if (!first_seen || data_last) begin
                        out_re = sat_re;
                        out_im = sat_im;
                    end else begin
                        out_re = data_re;
                        out_im = data_im;
                    end
                    if (data_last) state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (tx_clr) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            seg_cnt      <= '0;
            first_seen   <= 1'b0;
            data_en_q    <= 1'b0;
            tail_re      <= '0;
            tail_im      <= '0;
            sts_en       <= 1'b0;
            tx_re        <= '0;
            tx_im        <= '0;
            tx_dv        <= 1'b0;
            tx_index     <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            err_underrun <= 1'b0;
        end else if (tx_clr) begin
            state        <= ST_IDLE;
            seg_cnt      <= '0;
            first_seen   <= 1'b0;
            data_en_q    <= 1'b0;
            tail_re      <= '0;
            tail_im      <= '0;
            sts_en       <= 1'b0;
            tx_re        <= '0;
            tx_im        <= '0;
            tx_dv        <= 1'b0;
            tx_index     <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            seg_cnt <= seg_cnt_nxt;
            sts_en  <= start_ok;
            tx_dv   <= out_dv;
            if (out_dv) begin
                tx_re <= out_re;
                tx_im <= out_im;
            end
            if (start_ok)   tx_index <= '0;
            else if (tx_dv) tx_index <= tx_index + CNT_W'(1);
            tx_busy <= (state_nxt != ST_IDLE);
            tx_done <= (state == ST_TAIL);
            if (lts_end)       data_en_q <= 1'b1;
            else if (data_end) data_en_q <= 1'b0;
            if (state != ST_DATA) first_seen <= 1'b0;
            else if (data_hit)    first_seen <= 1'b1;
            if (tail_hit) begin
                tail_re <= lts_re;
                tail_im <= lts_im;
            end
            if (gap) err_underrun <= 1'b1;
        end
    end

endmodule
